pim_mac_sched: RTL and testbench

- Shares one pim_mac engine among NUM_REQ requesters. Each requester submits (base_addr, length) dot-product commands.
- Commands are granted round-robin into a small command FIFO. A dispatcher FSM issues them to the engine one at a time.
- On engine completion, the block pulses done to the originating requester.
- Sits between the GPU-side PIM command decoder and the bank-local MAC engine.

---
 rtl/pim_mac_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_pim_mac_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_mac_sched.sv
// pim_mac_sched: shares one bank-local MAC engine among NUM_REQ requesters.
// Commands are accepted by a round-robin arbiter into a small command FIFO.
// A dispatcher FSM sends them to the engine one at a time and pulses done
// back to the requester that issued each command.
// Optional performance counters are built when PIM_MAC_SCHED_PERF_EN is defined.
module pim_mac_sched #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_length,
    output logic [NUM_REQ-1:0]        done,
    output logic [ID_W-1:0]           done_id,
    output logic                      eng_start,
    output logic [ADDR_W-1:0]         eng_base_addr,
    output logic [LEN_W-1:0]          eng_length,
    input  logic                      eng_busy,
    output logic [ID_W+1:0]           fifo_level,
    output logic                      sched_busy
`ifdef PIM_MAC_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_cmds,
    output logic [31:0]               perf_busy_cycles,
    output logic [31:0]               perf_stall_cycles
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = ID_W + 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // Unpacked per-requester views of the flattened payload buses
    logic [ADDR_W-1:0] req_addr_arr [NUM_REQ];
    logic [LEN_W-1:0]  req_len_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_arr[gi] = req_base_addr[gi*ADDR_W +: ADDR_W];
            assign req_len_arr[gi]  = req_length[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // Arbiter and FIFO state
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [ID_W-1:0]   fifo_id_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [LEN_W-1:0]  fifo_len_q  [FIFO_DEPTH];

    // Dispatcher state
    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   cur_id_q;
    logic [ADDR_W-1:0] eng_addr_q;
    logic [LEN_W-1:0]  eng_len_q;
    logic              eng_start_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              can_push;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);

    // The dispatcher only pulls a command when idle and the engine is free;
    // a busy engine seen in IDLE belongs to someone else and blocks dispatch.
    assign pop      = (state_q == ST_IDLE) && !fifo_empty && !eng_busy;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign can_push = !fifo_full || pop;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [ID_W:0] idx;
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

    // One-hot ready on the granted requester; suppressed while in reset
    always_comb begin
        req_ready = '0;
        if (!rst && grant_found && can_push) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign push = |req_ready;

    // Next round-robin pointer: one past the accepted requester, else held
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Arbiter pointer, FIFO pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Command storage; contents are don't-care until the level counter covers them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q]   <= grant_idx;
            fifo_addr_q[wr_ptr_q] <= req_addr_arr[grant_idx];
            fifo_len_q[wr_ptr_q]  <= req_len_arr[grant_idx];
        end
    end

    // Dispatcher next-state: start, wait for busy, wait for completion, report
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (pop)       state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (eng_busy)  state_d = ST_RUN;
            ST_RUN:       if (!eng_busy) state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Dispatcher registers; the engine operands stay put until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_id_q    <= '0;
            eng_addr_q  <= '0;
            eng_len_q   <= '0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            eng_start_q <= pop;
            if (pop) begin
                cur_id_q   <= fifo_id_q[rd_ptr_q];
                eng_addr_q <= fifo_addr_q[rd_ptr_q];
                eng_len_q  <= fifo_len_q[rd_ptr_q];
            end
        end
    end

    // Completion pulse to the requester that owns the finished command
    always_comb begin
        done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_q == ST_DONE) && (cur_id_q == ID_W'(i))) begin
                done[i] = 1'b1;
            end
        end
    end

    assign done_id       = (state_q == ST_DONE) ? cur_id_q : '0;
    assign eng_start     = eng_start_q;
    assign eng_base_addr = eng_addr_q;
    assign eng_length    = eng_len_q;
    assign fifo_level    = level_q;
    assign sched_busy    = !fifo_empty || (state_q != ST_IDLE);

`ifdef PIM_MAC_SCHED_PERF_EN
    logic [31:0] perf_cmds_q;
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    // Saturating event counters: completions, engine-busy cycles, full-FIFO stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cmds_q  <= '0;
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q == ST_DONE) && (perf_cmds_q != '1)) begin
                perf_cmds_q <= perf_cmds_q + 32'd1;
            end
            if (eng_busy && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((|req_valid) && fifo_full && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cmds         = perf_cmds_q;
    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_pim_mac_sched.sv
// Directed testbench for pim_mac_sched with a behavioural MAC engine model.
module tb_pim_mac_sched;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 16;
    localparam int LEN_W   = 16;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_base_addr = '0;
    logic [NUM_REQ*LEN_W-1:0]  req_length = '0;
    logic [NUM_REQ-1:0]        done;
    logic [ID_W-1:0]           done_id;
    logic                      eng_start;
    logic [ADDR_W-1:0]         eng_base_addr;
    logic [LEN_W-1:0]          eng_length;
    logic                      eng_busy;
    logic [ID_W+1:0]           fifo_level;
    logic                      sched_busy;
`ifdef PIM_MAC_SCHED_PERF_EN
    logic [31:0]               perf_cmds;
    logic [31:0]               perf_busy_cycles;
    logic [31:0]               perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Engine model
    int busy_len   = 10;
    int eng_cnt    = 0;
    bit force_busy = 1'b0;

    // Monitor records
    int               acc_q[$];
    int               done_q[$];
    logic [ADDR_W-1:0] st_addr_q[$];
    logic [LEN_W-1:0]  st_len_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int multi_ready = 0;
    int done_bad    = 0;
    logic [3:0] one4 = 4'b0001;

    // Batch statistics
    int full_cycles = 0;
    int full_ready  = 0;
    int max_level   = 0;

    pim_mac_sched #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .FIFO_DEPTH(DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base_addr(req_base_addr), .req_length(req_length),
        .done(done), .done_id(done_id),
        .eng_start(eng_start), .eng_base_addr(eng_base_addr), .eng_length(eng_length),
        .eng_busy(eng_busy), .fifo_level(fifo_level), .sched_busy(sched_busy)
`ifdef PIM_MAC_SCHED_PERF_EN
        , .perf_cmds(perf_cmds), .perf_busy_cycles(perf_busy_cycles),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural engine: busy rises the cycle after start and lasts busy_len cycles
    always @(posedge clk) begin
        if (rst) eng_cnt <= 0;
        else if (eng_start) eng_cnt <= busy_len;
        else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    end
    assign eng_busy = (eng_cnt != 0) || force_busy;

    // Monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i]) acc_q.push_back(i);
            if (|done) begin
                done_q.push_back(int'(done_id));
                $display("done id=%0d vec=%b t=%0t", done_id, done, $time);
                if (done !== (one4 << done_id)) done_bad++;
            end
            if ($countones(req_ready) > 1) multi_ready++;
            if (eng_start) begin
                st_addr_q.push_back(eng_base_addr);
                st_len_q.push_back(eng_length);
                $display("start addr=%h len=%0d t=%0t", eng_base_addr, eng_length, $time);
            end
        end
    end

    task automatic clear_logs();
        acc_q.delete(); done_q.delete(); st_addr_q.delete(); st_len_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        force_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic set_payload(input int r, input logic [15:0] a, input logic [15:0] l);
        req_base_addr[r*ADDR_W +: ADDR_W] = a;
        req_length[r*LEN_W +: LEN_W] = l;
    endtask

    task automatic send(input int r, input logic [15:0] a, input logic [15:0] l);
        bit ok = 1'b0;
        set_payload(r, a, l);
        req_valid[r] = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (req_ready[r]) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL send_timeout req=%0d got no ready want ready", r); end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!sched_busy && !eng_busy) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_idle_timeout sched_busy=%b want 0", name, sched_busy); end
    endtask

    // Present n_i commands per requester, each valid held until accepted
    task automatic issue_batch(input int n0, input int n1, input int n2, input int n3,
                               input logic [15:0] base);
        int pend[4];
        int sent[4];
        int left;
        pend[0] = n0; pend[1] = n1; pend[2] = n2; pend[3] = n3;
        left = n0 + n1 + n2 + n3;
        full_cycles = 0; full_ready = 0; max_level = 0;
        exp_addr_q.delete();
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            set_payload(i, base + 16'(16*i), 16'd1);
            req_valid[i] = (pend[i] > 0);
        end
        for (int c = 0; c < 3000 && left > 0; c++) begin
            @(negedge clk);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (fifo_level == 4) begin
                full_cycles++;
                if (|req_ready) full_ready++;
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_addr_q.push_back(base + 16'(16*i + sent[i]));
                    pend[i]--; sent[i]++; left--;
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                set_payload(i, base + 16'(16*i + sent[i]), 16'(sent[i] + 1));
                req_valid[i] = (pend[i] > 0);
            end
        end
        req_valid = '0;
        checks++;
        if (left != 0) begin errors++; $display("FAIL batch_timeout left=%0d want 0", left); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, done, done_id, eng_start, fifo_level, sched_busy} !== '0 ||
            eng_base_addr !== 16'h0 || eng_length !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b done=%b id=%0d start=%b addr=%h len=%h lvl=%0d busy=%b want all 0",
                     req_ready, done, done_id, eng_start, eng_base_addr, eng_length, fifo_level, sched_busy);
        end
        reset_dut();
        @(negedge clk);
        checks++;
        if (fifo_level !== 0 || sched_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release lvl=%0d busy=%b want 0 0", fifo_level, sched_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        reset_dut();
        busy_len = 10;
        send(2, 16'h0100, 16'd4);
        wait_idle("single", 100);
        checks++;
        if (st_addr_q.size() != 1 || st_addr_q[0] !== 16'h0100 || st_len_q[0] !== 16'd4) begin
            errors++; $display("FAIL single_start n=%0d addr=%h len=%0d want 1 0100 4",
                               st_addr_q.size(), st_addr_q[0], st_len_q[0]);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 2) begin
            errors++; $display("FAIL single_done n=%0d id=%0d want 1 2", done_q.size(), done_q[0]);
        end
        checks++;
        if (sched_busy !== 1'b0 || fifo_level !== 0) begin
            errors++; $display("FAIL single_idle busy=%b lvl=%0d want 0 0", sched_busy, fifo_level);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        reset_dut();
        busy_len = 2;
        issue_batch(3, 2, 2, 2, 16'h1000);
        wait_idle("rr", 500);
        checks++;
        if (acc_q.size() != 9 || done_q.size() != 9 || st_addr_q.size() != 9) begin
            errors++; $display("FAIL rr_counts acc=%0d done=%0d start=%0d want 9 9 9",
                               acc_q.size(), done_q.size(), st_addr_q.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                $display("rr accept %0d req=%0d addr=%h", k, acc_q[k], st_addr_q[k]);
                checks++;
                if (acc_q[k] != exp_order[k] || done_q[k] != exp_order[k] ||
                    st_addr_q[k] !== exp_addr_q[k]) begin
                    errors++;
                    $display("FAIL rr_order k=%0d acc=%0d done=%0d addr=%h want %0d %0d %h",
                             k, acc_q[k], done_q[k], st_addr_q[k], exp_order[k], exp_order[k], exp_addr_q[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        reset_dut();
        busy_len = 50;
        issue_batch(2, 2, 1, 1, 16'h0200);
        wait_idle("bp", 2000);
        checks++;
        if (max_level != 4) begin
            errors++; $display("FAIL bp_max_level got %0d want 4", max_level);
        end
        checks++;
        if (full_ready != 1 || full_cycles < 40) begin
            errors++; $display("FAIL bp_full_ready ready_when_full=%0d full_cycles=%0d want 1 >=40",
                               full_ready, full_cycles);
        end
        checks++;
        if (acc_q.size() != 6 || done_q.size() != 6 || st_addr_q.size() != 6) begin
            errors++; $display("FAIL bp_counts acc=%0d done=%0d start=%0d want 6 6 6",
                               acc_q.size(), done_q.size(), st_addr_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (acc_q[k] != exp_order[k] || done_q[k] != exp_order[k] ||
                    st_addr_q[k] !== exp_addr_q[k]) begin
                    errors++;
                    $display("FAIL bp_order k=%0d acc=%0d done=%0d addr=%h want %0d %0d %h",
                             k, acc_q[k], done_q[k], st_addr_q[k], exp_order[k], exp_order[k], exp_addr_q[k]);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        reset_dut();
        busy_len = 1;
        send(1, 16'h0ABC, 16'd0);
        wait_idle("len0", 100);
        checks++;
        if (st_len_q.size() != 1 || st_len_q[0] !== 16'd0 || st_addr_q[0] !== 16'h0ABC) begin
            errors++; $display("FAIL len0_start n=%0d len=%0d addr=%h want 1 0 0abc",
                               st_len_q.size(), st_len_q[0], st_addr_q[0]);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 1) begin
            errors++; $display("FAIL len0_done n=%0d id=%0d want 1 1", done_q.size(), done_q[0]);
        end
    endtask

    task automatic test_foreign_busy();
        reset_dut();
        busy_len = 5;
        force_busy = 1'b1;
        send(3, 16'h0055, 16'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (st_addr_q.size() != 0 || fifo_level !== 1) begin
            errors++; $display("FAIL foreign_block starts=%0d lvl=%0d want 0 1", st_addr_q.size(), fifo_level);
        end
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_idle("foreign", 100);
        checks++;
        if (st_addr_q.size() != 1 || done_q.size() != 1 || done_q[0] != 3) begin
            errors++; $display("FAIL foreign_release starts=%0d dones=%0d id=%0d want 1 1 3",
                               st_addr_q.size(), done_q.size(), done_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        reset_dut();
        busy_len = 30;
        issue_batch(1, 1, 1, 0, 16'h0400);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (eng_busy) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || fifo_level !== 2) begin
            errors++; $display("FAIL rstmid_setup busy=%b lvl=%0d want 1 2", eng_busy, fifo_level);
        end
        @(posedge clk); #1 rst = 1'b1;
        clear_logs();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_level !== 0 || eng_start !== 1'b0 || sched_busy !== 1'b0 || done !== '0) begin
            errors++; $display("FAIL rstmid_clear lvl=%0d start=%b busy=%b done=%b want 0 0 0 0",
                               fifo_level, eng_start, sched_busy, done);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_q.size() != 0 || st_addr_q.size() != 0) begin
            errors++; $display("FAIL rstmid_quiet dones=%0d starts=%0d want 0 0", done_q.size(), st_addr_q.size());
        end
        busy_len = 4;
        send(2, 16'h0300, 16'd5);
        wait_idle("rstmid", 100);
        checks++;
        if (done_q.size() != 1 || done_q[0] != 2 || st_addr_q.size() != 1 || st_addr_q[0] !== 16'h0300) begin
            errors++; $display("FAIL rstmid_fresh dones=%0d id=%0d addr=%h want 1 2 0300",
                               done_q.size(), done_q[0], st_addr_q[0]);
        end
    endtask

`ifdef PIM_MAC_SCHED_PERF_EN
    task automatic test_perf();
        reset_dut();
        busy_len = 10;
        issue_batch(1, 1, 1, 0, 16'h0500);
        wait_idle("perf", 200);
        checks++;
        if (perf_cmds !== 32'd3 || perf_busy_cycles !== 32'd30 || perf_stall_cycles !== 32'd0) begin
            errors++; $display("FAIL perf_counters cmds=%0d busy=%0d stall=%0d want 3 30 0",
                               perf_cmds, perf_busy_cycles, perf_stall_cycles);
        end
    endtask
`endif

    task automatic test_invariants();
        checks++;
        if (multi_ready != 0) begin
            errors++; $display("FAIL ready_onehot multi_cycles=%0d want 0", multi_ready);
        end
        checks++;
        if (done_bad != 0) begin
            errors++; $display("FAIL done_vs_id bad_cycles=%0d want 0", done_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_len_zero();
        test_foreign_busy();
        test_reset_mid();
`ifdef PIM_MAC_SCHED_PERF_EN
        test_perf();
`endif
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
